histogram_cdf: RTL and testbench
================================

// Module: histogram_cdf
// PURPOSE
//   Front half of the histogram-equalisation path: counts every pixel of a frame
//   into BINS bins, then builds the cumulative distribution table, cdf_min and the
//   pixel total. The equalizer downstream reads these through a 1-cycle lookup
//   port. Sits between the pixel source and the equalizer.
// PARAMETERS
//   PIX_W  8    pixel width; BINS = 2**PIX_W (256)
//   CNT_W  32   width of every bin count, CDF entry, cdf_min and total_pixels
// PORTS
//   clk           in   1      single clock, all logic on rising edge
//   reset         in   1      asynchronous, active-high; clears all state and outputs
//   pixel_in      in   PIX_W  input pixel value
//   valid         in   1      pixel_in qualifier
//   last          in   1      marks final pixel of frame; only meaningful with valid
//   ready         out  1      block accepts a pixel this cycle (valid && ready)
//   lut_addr      in   PIX_W  CDF lookup address (the equalizer's pixel)
//   cdf_data      out  CNT_W  registered CDF entry for lut_addr, 1-cycle latency
//   cdf_min       out  CNT_W  CDF value at first non-zero bin of last completed frame
//   total_pixels  out  CNT_W  pixel count of last completed frame (= CDF[BINS-1])
//   cdf_valid     out  1      CDF table, cdf_min and total_pixels are consistent
//   frame_done    out  1      1-cycle pulse when a new table is published
// BEHAVIOUR
//   Reset values: ready=0, cdf_data=0, cdf_min=0, total_pixels=0, cdf_valid=0,
//     frame_done=0; state=CLEAR, idx=0.
//   Storage: hist[BINS] and cdf[BINS], each CNT_W wide, register arrays.
//   FSM states:
//   CLEAR : ready=0. Writes hist[idx]=0 and cdf[idx]=0, idx++. idx==BINS-1 -> ACCUM.
//           Lasts exactly BINS cycles after reset deasserts.
//   ACCUM : ready=1. On valid&&ready: hist[pixel_in] += 1 (saturates at
//           2**CNT_W-1). Repeated values on consecutive cycles each count; no
//           RMW hazard. If last is also set, that pixel is counted and the next
//           state is SCAN, with idx=0, acc=0, min_found=0.
//   SCAN  : ready=0; valid is ignored and nothing is counted. Each cycle:
//           s = acc + hist[idx] (saturating); cdf[idx]<=s; acc<=s; hist[idx]<=0.
//           If hist[idx]!=0 && !min_found: cdf_min_nxt<=s, min_found<=1.
//           At idx==BINS-1: cdf_min<=cdf_min_nxt, total_pixels<=s, cdf_valid<=1,
//           frame_done<=1 for one cycle, -> ACCUM.
//   Timing: last accepted in cycle T -> SCAN occupies T+1..T+BINS -> cdf_valid=1,
//     frame_done=1 and ready=1 in cycle T+BINS+1.
//   cdf_valid falls on the first SCAN cycle and stays low until publish. cdf_min
//     and total_pixels change only at publish.
//   Lookup: cdf_data <= cdf[lut_addr] every cycle, in all states. During SCAN it
//     may return mixed old/new entries, and consumers must qualify with cdf_valid.
//   A frame whose bins are all zero cannot occur, because last needs valid.
//     min_found is always set by publish.
//   Reset mid-SCAN or mid-ACCUM: all partial counts are discarded and CLEAR reruns.
//   Saturation is sticky per bin and per accumulator. There is no wrap-around.
// TESTING
//   1 Reset release -> ready=0 for exactly 256 cycles, then 1. cdf_valid=0 and
//     cdf_data=0 for every lut_addr.
//   2 Frame {10,10,20,255(last)} -> ready low 256 cycles, then frame_done pulse.
//     cdf[9]=0, cdf[10]=2, cdf[19]=2, cdf[20]=3, cdf[254]=3, cdf[255]=4;
//     cdf_min=2, total_pixels=4.
//   3 Second frame {0(last)} after test 2 -> cdf[0..255]=1, cdf_min=1,
//     total_pixels=1. Confirms the histogram was cleared by the scan.
//   4 1000 back-to-back pixels of 128, last on the final one -> cdf[127]=0,
//     cdf[128..255]=1000, cdf_min=1000. Pulse valid during SCAN: ignored and
//     totals unchanged.
//   5 Assert reset 100 cycles into SCAN -> cdf_valid=0, ready=0 for 256 cycles.
//     Then frame {7(last)} gives cdf_min=1 and total=1.
//   6 CNT_W=4: 20 pixels of 5 plus 1 pixel of 6 (last) -> cdf[5]=15,
//     cdf[6]=15 (saturated), total_pixels=15, cdf_min=15.

Source files
------------

// File: rtl/histogram_cdf_if.sv
`default_nettype none
// ============================================================================
// Module   : histogram_cdf_if
// Brief    : Pixel stream, CDF lookup and frame-summary bundle of histogram_cdf.
// Revision : 1.0  initial release
// ============================================================================
interface histogram_cdf_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 32
);
    logic [PIX_W-1:0] pixel_in;
    logic             valid;
    logic             last;
    logic             ready;
    logic [PIX_W-1:0] lut_addr;
    logic [CNT_W-1:0] cdf_data;
    logic [CNT_W-1:0] cdf_min;
    logic [CNT_W-1:0] total_pixels;
    logic             cdf_valid;
    logic             frame_done;

    modport master (
        output pixel_in, valid, last, lut_addr,
        input  ready, cdf_data, cdf_min, total_pixels, cdf_valid, frame_done
    );

    modport slave (
        input  pixel_in, valid, last, lut_addr,
        output ready, cdf_data, cdf_min, total_pixels, cdf_valid, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/histogram_cdf.sv
`default_nettype none
// ============================================================================
// Module   : histogram_cdf
// Brief    : Per-frame pixel histogram, cumulative table, cdf_min and total.
// Revision : 1.0  initial release
// ============================================================================
module histogram_cdf #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 32
) (
    input wire             clk,
    input wire             reset,
    histogram_cdf_if.slave bus
);
    localparam int               BINS     = 2**PIX_W;
    localparam logic [PIX_W-1:0] LAST_IDX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_ACCUM = 2'd1,
        S_SCAN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [PIX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_hist [BINS];
    logic [CNT_W-1:0] r_cdf  [BINS];
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_min_nxt;
    logic             r_min_found;
    logic             r_ready;
    logic [CNT_W-1:0] r_cdf_min;
    logic [CNT_W-1:0] r_total;
    logic             r_cdf_valid;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_cdf_data;

    logic             w_accept;
    logic [CNT_W-1:0] w_bin;
    logic [CNT_W:0]   w_sum_wide;
    logic [CNT_W-1:0] w_sum;
    logic [CNT_W-1:0] w_pix_cnt;
    logic [CNT_W-1:0] w_pix_inc;
    logic [CNT_W-1:0] w_min_sel;

    assign w_accept   = bus.valid && r_ready;
    assign w_bin      = r_hist[r_idx];
    assign w_sum_wide = {1'b0, r_acc} + {1'b0, w_bin};
    assign w_sum      = w_sum_wide[CNT_W] ? CNT_MAX : w_sum_wide[CNT_W-1:0];
    assign w_pix_cnt  = r_hist[bus.pixel_in];
    assign w_pix_inc  = (w_pix_cnt == CNT_MAX) ? CNT_MAX : w_pix_cnt + CNT_W'(1);
    // Bypass so a first non-zero bin found on the final scan step still publishes.
    assign w_min_sel  = (w_bin != '0 && !r_min_found) ? w_sum : r_min_nxt;

    // Table storage: no reset, the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        case (r_state)
            S_CLEAR: begin
                r_hist[r_idx] <= '0;
                r_cdf[r_idx]  <= '0;
            end
            S_ACCUM: begin
                if (w_accept) begin
                    r_hist[bus.pixel_in] <= w_pix_inc;
                end
            end
            S_SCAN: begin
                r_cdf[r_idx]  <= w_sum;
                r_hist[r_idx] <= '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_CLEAR;
            r_idx        <= '0;
            r_acc        <= '0;
            r_min_nxt    <= '0;
            r_min_found  <= 1'b0;
            r_ready      <= 1'b0;
            r_cdf_min    <= '0;
            r_total      <= '0;
            r_cdf_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_idx <= r_idx + PIX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_ACCUM;
                        r_ready <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_accept && bus.last) begin
                        r_state     <= S_SCAN;
                        r_ready     <= 1'b0;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_min_found <= 1'b0;
                        r_cdf_valid <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_acc       <= w_sum;
                    r_idx       <= r_idx + PIX_W'(1);
                    r_min_nxt   <= w_min_sel;
                    r_min_found <= r_min_found | (w_bin != '0);
                    if (r_idx == LAST_IDX) begin
                        r_cdf_min    <= w_min_sel;
                        r_total      <= w_sum;
                        r_cdf_valid  <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= S_ACCUM;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_idx   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Lookup runs in every state; consumers qualify with cdf_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdf_data <= '0;
        end else begin
            r_cdf_data <= r_cdf[bus.lut_addr];
        end
    end

    assign bus.ready        = r_ready;
    assign bus.cdf_data     = r_cdf_data;
    assign bus.cdf_min      = r_cdf_min;
    assign bus.total_pixels = r_total;
    assign bus.cdf_valid    = r_cdf_valid;
    assign bus.frame_done   = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_histogram_cdf.sv
`default_nettype none
// ============================================================================
// Module   : tb_histogram_cdf
// Brief    : Self-checking bench for histogram_cdf (32-bit and 4-bit counters).
// Revision : 1.0  initial release
// ============================================================================
module tb_histogram_cdf;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    histogram_cdf_if #(.PIX_W(8), .CNT_W(32)) bus ();
    histogram_cdf_if #(.PIX_W(8), .CNT_W(4))  bus4 ();

    histogram_cdf #(.PIX_W(8), .CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
    histogram_cdf #(.PIX_W(8), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int          n_total = 0;
    int          n_pass  = 0;
    longint      exp_cdf [256];
    longint      exp_min;
    longint      exp_total;
    logic [31:0] got [256];

    function automatic logic f_ready(bit s);  return s ? bus4.ready      : bus.ready;      endfunction
    function automatic logic f_done(bit s);   return s ? bus4.frame_done : bus.frame_done; endfunction
    function automatic logic f_cvalid(bit s); return s ? bus4.cdf_valid  : bus.cdf_valid;  endfunction
    function automatic logic [31:0] f_data(bit s);  return s ? {28'd0, bus4.cdf_data}     : bus.cdf_data;     endfunction
    function automatic logic [31:0] f_min(bit s);   return s ? {28'd0, bus4.cdf_min}      : bus.cdf_min;      endfunction
    function automatic logic [31:0] f_total(bit s); return s ? {28'd0, bus4.total_pixels} : bus.total_pixels; endfunction

    task automatic drive(input bit s, input logic v, input logic [7:0] p, input logic l);
        if (s) begin bus4.valid = v; bus4.pixel_in = p; bus4.last = l; end
        else   begin bus.valid  = v; bus.pixel_in  = p; bus.last  = l; end
    endtask

    // Reference: CDF entry k is the number of frame pixels <= k, clipped to the counter maximum.
    task automatic build_model(input logic [7:0] pix[$], input longint maxv);
        longint cnt [256];
        longint run = 0;
        int     lo  = 255;
        foreach (cnt[k]) cnt[k] = 0;
        foreach (pix[i]) begin
            cnt[pix[i]]++;
            if (int'(pix[i]) < lo) lo = int'(pix[i]);
        end
        for (int k = 0; k < 256; k++) begin
            run        += cnt[k];
            exp_cdf[k] = (run > maxv) ? maxv : run;
        end
        exp_min   = exp_cdf[lo];
        exp_total = exp_cdf[255];
    endtask

    task automatic send_frame(input bit s, input logic [7:0] pix[$], input bit gaps,
                              output int cycles, output int sent);
        sent   = 0;
        cycles = 0;
        while (sent < pix.size() && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (f_ready(s) && (!gaps || $urandom_range(3) != 0)) begin
                drive(s, 1'b1, pix[sent], (sent == pix.size() - 1));
                sent++;
            end else begin
                drive(s, 1'b0, 8'($urandom), 1'b0);
            end
        end
        @(negedge clk);
        drive(s, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wait_publish(input bit s, input bit pulse, output int cnt, output int low,
                                output bit cv_scan, output bit rdy_pub, output bit cv_pub, output bit drop);
        cnt     = 0;
        low     = 0;
        cv_scan = f_cvalid(s);
        while (!f_done(s) && cnt < 400) begin
            if (pulse) drive(s, 1'($urandom), 8'($urandom), 1'($urandom));
            if (!f_ready(s)) low++;
            @(negedge clk);
            cnt++;
        end
        drive(s, 1'b0, 8'd0, 1'b0);
        rdy_pub = f_ready(s);
        cv_pub  = f_cvalid(s);
        @(negedge clk);
        drop = !f_done(s);
    endtask

    task automatic dump(input bit s);
        @(negedge clk);
        if (s) bus4.lut_addr = 8'd0; else bus.lut_addr = 8'd0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            got[k] = f_data(s);
            if (s) bus4.lut_addr = 8'(k + 1); else bus.lut_addr = 8'(k + 1);
        end
    endtask

    task automatic release_reset(output int clr);
        @(negedge clk);
        reset = 1'b0;
        clr   = 0;
        do begin
            @(posedge clk);
            #1;
            clr++;
        end while (!bus.ready && clr < 1000);
    endtask

    task automatic test_reset();
        int clr;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.ready, bus.cdf_valid, bus.frame_done} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {bus.ready, bus.cdf_valid, bus.frame_done});
        else n_pass++;
        n_total++;
        if ({bus.cdf_min, bus.total_pixels, bus.cdf_data} !== 96'd0)
            $display("FAIL reset_values: got min=%0d total=%0d data=%0d expected 0", bus.cdf_min, bus.total_pixels, bus.cdf_data);
        else n_pass++;
        release_reset(clr);
        n_total++;
        if (clr !== 256) $display("FAIL clear_length: got %0d cycles expected 256", clr); else n_pass++;
        n_total++;
        if (bus.cdf_valid !== 1'b0) $display("FAIL clear_cdf_valid: got %b expected 0", bus.cdf_valid); else n_pass++;
        dump(1'b0);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (got[k] !== 32'd0) $display("FAIL clear_table[%0d]: got %0d expected 0", k, got[k]); else n_pass++;
        end
    endtask

    task automatic test_first_frame();
        logic [7:0] q[$];
        int cyc, sent, cnt, low;
        bit cvs, rdy, cvp, drop;
        q = {8'd10, 8'd10, 8'd20, 8'd255};
        build_model(q, longint'(32'hFFFF_FFFF));
        send_frame(1'b0, q, 1'b0, cyc, sent);
        wait_publish(1'b0, 1'b0, cnt, low, cvs, rdy, cvp, drop);
        n_total++;
        if (cnt !== 256) $display("FAIL scan_latency: got %0d expected 256", cnt); else n_pass++;
        n_total++;
        if (low !== 256) $display("FAIL scan_ready_low: got %0d expected 256", low); else n_pass++;
        n_total++;
        if ({cvs, rdy, cvp, drop} !== 4'b0111)
            $display("FAIL publish_flags: got cv_scan=%b ready=%b cv=%b drop=%b expected 0111", cvs, rdy, cvp, drop);
        else n_pass++;
        n_total++;
        if (bus.cdf_min !== 32'd2 || bus.total_pixels !== 32'd4)
            $display("FAIL frame1_summary: got min=%0d total=%0d expected min=2 total=4", bus.cdf_min, bus.total_pixels);
        else n_pass++;
        dump(1'b0);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (got[k] !== 32'(exp_cdf[k])) $display("FAIL frame1_cdf[%0d]: got %0d expected %0d", k, got[k], exp_cdf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_second_frame();
        logic [7:0] q[$];
        int cyc, sent, cnt, low;
        bit cvs, rdy, cvp, drop;
        q = {8'd0};
        build_model(q, longint'(32'hFFFF_FFFF));
        send_frame(1'b0, q, 1'b0, cyc, sent);
        wait_publish(1'b0, 1'b0, cnt, low, cvs, rdy, cvp, drop);
        n_total++;
        if (bus.cdf_min !== 32'(exp_min) || bus.total_pixels !== 32'(exp_total))
            $display("FAIL frame2_summary: got min=%0d total=%0d expected %0d/%0d", bus.cdf_min, bus.total_pixels, exp_min, exp_total);
        else n_pass++;
        dump(1'b0);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (got[k] !== 32'(exp_cdf[k])) $display("FAIL frame2_cdf[%0d]: got %0d expected %0d", k, got[k], exp_cdf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int cyc, sent, cnt, low;
        bit cvs, rdy, cvp, drop;
        for (int i = 0; i < 1000; i++) q.push_back(8'd128);
        build_model(q, longint'(32'hFFFF_FFFF));
        send_frame(1'b0, q, 1'b0, cyc, sent);
        n_total++;
        if (cyc !== 1000) $display("FAIL b2b_cycles: got %0d expected 1000", cyc); else n_pass++;
        wait_publish(1'b0, 1'b1, cnt, low, cvs, rdy, cvp, drop);
        n_total++;
        if (cnt !== 256 || low !== 256) $display("FAIL b2b_scan: got cnt=%0d low=%0d expected 256/256", cnt, low); else n_pass++;
        n_total++;
        if (bus.cdf_min !== 32'd1000 || bus.total_pixels !== 32'd1000)
            $display("FAIL b2b_summary: got min=%0d total=%0d expected 1000/1000", bus.cdf_min, bus.total_pixels);
        else n_pass++;
        dump(1'b0);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (got[k] !== 32'(exp_cdf[k])) $display("FAIL b2b_cdf[%0d]: got %0d expected %0d", k, got[k], exp_cdf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] q[$];
        int cyc, sent, cnt, low, n;
        bit cvs, rdy, cvp, drop;
        logic [7:0] base;
        for (int f = 0; f < 3; f++) begin
            q.delete();
            n    = $urandom_range(300, 1);
            base = 8'($urandom);
            for (int i = 0; i < n; i++)
                q.push_back((f == 1) ? 8'(base + 8'($urandom_range(7))) : 8'($urandom));
            build_model(q, longint'(32'hFFFF_FFFF));
            send_frame(1'b0, q, 1'b1, cyc, sent);
            n_total++;
            if (sent !== n) $display("FAIL rand_sent: got %0d expected %0d", sent, n); else n_pass++;
            wait_publish(1'b0, 1'b0, cnt, low, cvs, rdy, cvp, drop);
            n_total++;
            if (bus.cdf_min !== 32'(exp_min) || bus.total_pixels !== 32'(exp_total))
                $display("FAIL rand_summary: got min=%0d total=%0d expected %0d/%0d", bus.cdf_min, bus.total_pixels, exp_min, exp_total);
            else n_pass++;
            dump(1'b0);
            for (int k = 0; k < 256; k++) begin
                n_total++;
                if (got[k] !== 32'(exp_cdf[k])) $display("FAIL rand_cdf[%0d]: got %0d expected %0d", k, got[k], exp_cdf[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] q[$];
        int cyc, sent, cnt, low, clr;
        bit cvs, rdy, cvp, drop;
        for (int i = 0; i < 50; i++) q.push_back(8'($urandom));
        send_frame(1'b0, q, 1'b0, cyc, sent);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus.cdf_valid, bus.ready} !== 2'b00 || bus.total_pixels !== 32'd0)
            $display("FAIL midscan_reset: got cv=%b ready=%b total=%0d expected 0 0 0", bus.cdf_valid, bus.ready, bus.total_pixels);
        else n_pass++;
        repeat (2) @(negedge clk);
        release_reset(clr);
        n_total++;
        if (clr !== 256) $display("FAIL midscan_clear: got %0d cycles expected 256", clr); else n_pass++;
        q = {8'd7};
        build_model(q, longint'(32'hFFFF_FFFF));
        send_frame(1'b0, q, 1'b0, cyc, sent);
        wait_publish(1'b0, 1'b0, cnt, low, cvs, rdy, cvp, drop);
        n_total++;
        if (bus.cdf_min !== 32'd1 || bus.total_pixels !== 32'd1)
            $display("FAIL midscan_summary: got min=%0d total=%0d expected 1/1", bus.cdf_min, bus.total_pixels);
        else n_pass++;
        dump(1'b0);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (got[k] !== 32'(exp_cdf[k])) $display("FAIL midscan_cdf[%0d]: got %0d expected %0d", k, got[k], exp_cdf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] q[$];
        int cyc, sent, cnt, low;
        bit cvs, rdy, cvp, drop;
        for (int i = 0; i < 20; i++) q.push_back(8'd5);
        q.push_back(8'd6);
        build_model(q, 64'd15);
        send_frame(1'b1, q, 1'b0, cyc, sent);
        wait_publish(1'b1, 1'b0, cnt, low, cvs, rdy, cvp, drop);
        n_total++;
        if (cnt !== 256) $display("FAIL sat_latency: got %0d expected 256", cnt); else n_pass++;
        n_total++;
        if (f_min(1'b1) !== 32'd15 || f_total(1'b1) !== 32'd15)
            $display("FAIL sat_summary: got min=%0d total=%0d expected 15/15", f_min(1'b1), f_total(1'b1));
        else n_pass++;
        dump(1'b1);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (got[k] !== 32'(exp_cdf[k])) $display("FAIL sat_cdf[%0d]: got %0d expected %0d", k, got[k], exp_cdf[k]);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b0);
        bus.lut_addr  = 8'd0;
        bus4.lut_addr = 8'd0;
        test_reset();
        test_first_frame();
        test_second_frame();
        test_back_to_back();
        test_random_frames();
        test_reset_mid_scan();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
